// File: rtl/bus_arbiter_5ch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_5ch_if
//  Description : Request/grant bundle between five bus masters and the
//                bus_arbiter_5ch round-robin arbiter.
//                  req      [4:0] per-channel requests (bit i = channel i)
//                  grant    [4:0] one-hot or all-zero registered grant
//                  sel      [2:0] registered mux select (owner index/idle)
//                  busy           high while any channel is granted
//                  hold_cnt [3:0] consecutive cycles the owner has held
//                master : requester side (drives req)
//                slave  : arbiter side   (drives grant/sel/busy/hold_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_5ch_if;
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [3:0] hold_cnt;

    modport master (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  hold_cnt
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output busy,
        output hold_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_5ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_5ch
//  Description : Five-channel round-robin bus arbiter with bounded tenure.
//                An owner keeps the bus while it requests, for at most
//                MAX_HOLD consecutive cycles when someone else is waiting.
//                Hand-over to the next round-robin winner happens with no
//                idle cycle in between.
//  Ports       : clk  - clock, rising edge active
//                rst  - synchronous active-high reset
//                bus  - bus_arbiter_5ch_if.slave (req in; grant, sel,
//                       busy, hold_cnt out, all registered)
//  Parameters  : MAX_HOLD - max consecutive grant cycles under contention
//                           (1..15)
//                IDLE_SEL - select code driven while nothing is granted
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_5ch #(
    parameter int         MAX_HOLD = 4,
    parameter logic [2:0] IDLE_SEL = 3'b111
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bus_arbiter_5ch_if.slave   bus
);

    localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);
    localparam logic [2:0] c_last_ch  = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [4:0] r_grant;
    logic [2:0] r_sel;
    logic       r_busy;
    logic [3:0] r_hold;
    logic [2:0] r_ptr;

    state_t     w_state_nxt;
    logic [4:0] w_grant_nxt;
    logic [2:0] w_sel_nxt;
    logic       w_busy_nxt;
    logic [3:0] w_hold_nxt;
    logic [2:0] w_ptr_nxt;

    logic       w_owner_req;
    logic [4:0] w_others;
    logic [2:0] w_win;

    // Index following idx in the 0..4 ring.
    function automatic logic [2:0] f_ring_next(input logic [2:0] idx);
        return (idx == c_last_ch) ? 3'd0 : idx + 3'd1;
    endfunction

    // First set bit of mask, searching from ptr upward and wrapping 4->0.
    function automatic logic [2:0] f_rr_pick(input logic [4:0] mask,
                                             input logic [2:0] ptr);
        logic [2:0] v_idx;
        logic [2:0] v_pick;
        logic       v_found;
        v_idx   = ptr;
        v_pick  = 3'd0;
        v_found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!v_found && mask[v_idx]) begin
                v_pick  = v_idx;
                v_found = 1'b1;
            end
            v_idx = f_ring_next(v_idx);
        end
        return v_pick;
    endfunction

    // r_grant is all-zero in IDLE, so w_others equals req there and
    // excludes the current owner while in GRANT.
    assign w_owner_req = |(bus.req & r_grant);
    assign w_others    = bus.req & ~r_grant;
    assign w_win       = f_rr_pick(w_others, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_hold_nxt  = r_hold;
        w_ptr_nxt   = r_ptr;

        case (r_state)
            ST_IDLE: begin
                if (w_others != 5'd0) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = 5'b00001 << w_win;
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = 4'd1;
                    w_ptr_nxt   = f_ring_next(w_win);
                end
            end

            ST_GRANT: begin
                if (w_owner_req && (r_hold < c_max_hold)) begin
                    w_hold_nxt = r_hold + 4'd1;
                end else if (w_owner_req && (w_others == 5'd0)) begin
                    // Tenure exhausted but nobody is waiting: keep, saturate.
                    w_hold_nxt = c_max_hold;
                end else if (w_others != 5'd0) begin
                    // Owner released or is preempted: hand over directly.
                    w_grant_nxt = 5'b00001 << w_win;
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = 4'd1;
                    w_ptr_nxt   = f_ring_next(w_win);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 5'd0;
                    w_sel_nxt   = IDLE_SEL;
                    w_busy_nxt  = 1'b0;
                    w_hold_nxt  = 4'd0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 5'd0;
                w_sel_nxt   = IDLE_SEL;
                w_busy_nxt  = 1'b0;
                w_hold_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 5'd0;
            r_sel   <= IDLE_SEL;
            r_busy  <= 1'b0;
            r_hold  <= 4'd0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_hold  <= w_hold_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.sel      = r_sel;
    assign bus.busy     = r_busy;
    assign bus.hold_cnt = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_5ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_5ch
//  Description : Self-checking bench for bus_arbiter_5ch. A table of
//                hand-derived vectors covers the directed scenarios, a
//                hand-written sequence covers preemption after saturation,
//                and a behavioural model drives a randomised phase.
//                Expected outputs are queued when stimulus is applied and
//                compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_5ch;

    localparam int         c_max_hold = 4;
    localparam logic [2:0] c_idle_sel = 3'b111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter_5ch_if bus ();

    bus_arbiter_5ch #(
        .MAX_HOLD (c_max_hold),
        .IDLE_SEL (c_idle_sel)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic [3:0] hold;
    } vec_t;

    typedef struct {
        int         id;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic [3:0] hold;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state for the random phase.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    task automatic add(input logic r, input logic [4:0] q, input logic [4:0] g,
                       input logic [2:0] s, input logic b, input logic [3:0] h);
        vec_t v;
        v.rst = r; v.req = q; v.grant = g; v.sel = s; v.busy = b; v.hold = h;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input logic r, input logic [4:0] q);
        add(r, q, 5'd0, c_idle_sel, 1'b0, 4'd0);
    endtask

    task automatic check_one();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: empty queue at check %0d", n_checks);
        end else begin
            e = sb.pop_front();
            if (bus.grant === e.grant && bus.sel === e.sel &&
                bus.busy === e.busy && bus.hold_cnt === e.hold) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got grant=%b sel=%0d busy=%b hold=%0d, want grant=%b sel=%0d busy=%b hold=%0d",
                         e.id, bus.grant, bus.sel, bus.busy, bus.hold_cnt,
                         e.grant, e.sel, e.busy, e.hold);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after edge.
    task automatic apply(input int id, input logic r, input logic [4:0] q,
                         input logic [4:0] g, input logic [2:0] s,
                         input logic b, input logic [3:0] h);
        exp_t e;
        rst     = r;
        bus.req = q;
        e.id = id; e.grant = g; e.sel = s; e.busy = b; e.hold = h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    task automatic model_step(input logic r, input logic [4:0] q,
                              output logic [4:0] g, output logic [2:0] s,
                              output logic b, output logic [3:0] h);
        logic [4:0] others;
        bit         keep;
        int         w;
        if (r) begin
            m_owner = -1; m_hold = 0; m_ptr = 0;
        end else begin
            others = q;
            if (m_owner >= 0) others[m_owner] = 1'b0;
            keep = (m_owner >= 0) && q[m_owner] &&
                   ((m_hold < c_max_hold) || (others == 5'd0));
            if (keep) begin
                if (m_hold < c_max_hold) m_hold++;
            end else if (others == 5'd0) begin
                m_owner = -1; m_hold = 0;
            end else begin
                w = -1;
                for (int k = 0; k < 5; k++) begin
                    if (w < 0 && others[(m_ptr + k) % 5]) w = (m_ptr + k) % 5;
                end
                m_owner = w; m_hold = 1; m_ptr = (w + 1) % 5;
            end
        end
        g = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
        s = (m_owner < 0) ? c_idle_sel : 3'(m_owner);
        b = (m_owner >= 0);
        h = 4'(m_hold);
    endtask

    initial begin
        logic [4:0] q;
        logic [4:0] g;
        logic [2:0] s;
        logic       b;
        logic [3:0] h;
        logic       r;
        int         ch;

        rst     = 1'b1;
        bus.req = 5'd0;

        // Single requester, 1-cycle latency; reset ignores req.
        add_idle(1'b1, 5'b11111);
        add(1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1);
        add_idle(1'b0, 5'b00000);
        // Full contention: each channel for MAX_HOLD cycles, no gaps.
        add_idle(1'b1, 5'b00000);
        for (int c = 0; c < 6; c++) begin
            ch = c % 5;
            for (int hh = 1; hh <= c_max_hold; hh++)
                add(1'b0, 5'b11111, 5'(1 << ch), 3'(ch), 1'b1, 4'(hh));
        end
        // ch0 releases -> ch1; ch1 releases with only ch4 asking -> ch4.
        add(1'b0, 5'b00010, 5'b00010, 3'd1, 1'b1, 4'd1);
        add(1'b0, 5'b10000, 5'b10000, 3'd4, 1'b1, 4'd1);
        add_idle(1'b0, 5'b00000);
        // Pointer wrapped to 0: ch0 wins, then pointer 1 favours ch1.
        add(1'b0, 5'b00011, 5'b00001, 3'd0, 1'b1, 4'd1);
        add_idle(1'b0, 5'b00000);
        add(1'b0, 5'b00011, 5'b00010, 3'd1, 1'b1, 4'd1);
        add_idle(1'b0, 5'b00000);
        // Lone ch3 for 10 cycles: hold saturates.
        for (int i = 0; i < 10; i++)
            add(1'b0, 5'b01000, 5'b01000, 3'd3, 1'b1, (i < 3) ? 4'(i + 1) : 4'd4);
        add_idle(1'b0, 5'b00000);
        // Reset mid-grant, then restart from pointer 0.
        add(1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1);
        add(1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd2);
        add_idle(1'b1, 5'b00100);
        add(1'b0, 5'b11111, 5'b00001, 3'd0, 1'b1, 4'd1);

        @(negedge clk);
        foreach (vecs[i])
            apply(i, vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].sel,
                  vecs[i].busy, vecs[i].hold);

        // Saturated owner preempted the moment another channel asks.
        // Pointer is 1 here (after ch0), ch2 wins, pointer -> 3.
        apply(100, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1);
        apply(101, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd2);
        apply(102, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd3);
        apply(103, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd4);
        apply(104, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd4);
        apply(105, 1'b0, 5'b00101, 5'b00001, 3'd0, 1'b1, 4'd1);
        apply(106, 1'b0, 5'b00101, 5'b00001, 3'd0, 1'b1, 4'd2);
        apply(107, 1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 4'd1);

        // Randomised phase against the behavioural model.
        q = 5'd0;
        for (int i = 0; i < 400; i++) begin
            r = (i == 0) || ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 4) q = 5'($urandom_range(0, 31));
            model_step(r, q, g, s, b, h);
            apply(1000 + i, r, q, g, s, b, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
